// File: rtl/bram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_loader_pkg
// Description : Shared CNN constants and loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_loader_pkg;

   localparam int WORD_W = 64;
   localparam int BYTE_W = 8;
   localparam int ADDR_W = 7;
   localparam int DEPTH  = 128;
   localparam int LANES  = WORD_W / BYTE_W;
   localparam int LANE_W = $clog2(LANES);
   localparam int NUMW_W = 8;

   localparam logic [NUMW_W-1:0] MAX_WORDS = NUMW_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Requests beyond the BRAM depth are clamped to a full-buffer load.
   function automatic logic [NUMW_W-1:0] sat_words(input logic [NUMW_W-1:0] n);
      return (n > MAX_WORDS) ? MAX_WORDS : n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_loader.sv
`default_nettype none
// ============================================================================
// Module      : bram_loader
// Description : Packs a byte stream into 64-bit little-endian words and
//               writes them to consecutive BRAM rows.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_loader
   import bram_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NUMW_W-1:0] num_words,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] data_in,
   output logic              busy,
   output logic              done
);

   state_t              r_state;
   state_t              w_next;
   logic [NUMW_W-1:0]   r_target;
   logic [NUMW_W-1:0]   r_word_cnt;
   logic [LANE_W-1:0]   r_byte_cnt;
   logic [WORD_W-1:0]   r_pack;
   logic [WORD_W-1:0]   r_data_in;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic                r_we;

   logic                w_start_ok;
   logic                w_accept;
   logic                w_last_byte;

   assign w_start_ok  = (r_state == ST_IDLE) && start;
   assign w_accept    = in_ready && in_valid;
   assign w_last_byte = w_accept && (r_byte_cnt == LANE_W'(LANES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Abort also drops in_ready so the source never sees a handshake for a
   // byte the loader is about to discard.
   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = (sat_words(num_words) == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            busy     = 1'b1;
            in_ready = (r_word_cnt < r_target) && !abort;
            if (abort) begin
               w_next = ST_IDLE;
            end else if (r_we && (r_word_cnt == r_target)) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_target   <= '0;
         r_word_cnt <= '0;
         r_byte_cnt <= '0;
         r_pack     <= '0;
         r_data_in  <= '0;
         r_wr_addr  <= '0;
         r_we       <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (w_start_ok) begin
            r_target   <= sat_words(num_words);
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_pack     <= '0;
         end else if (w_accept) begin
            r_pack[{r_byte_cnt, 3'b000} +: BYTE_W] <= in_data;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            // The word leaves the packer here, freeing it for the next byte.
            if (w_last_byte) begin
               r_we       <= 1'b1;
               r_wr_addr  <= r_word_cnt[ADDR_W-1:0];
               r_data_in  <= {in_data, r_pack[WORD_W-BYTE_W-1:0]};
               r_word_cnt <= r_word_cnt + 1'b1;
            end
         end
      end
   end

   assign we      = r_we;
   assign wr_addr = r_wr_addr;
   assign data_in = r_data_in;

endmodule
`default_nettype wire
